// File: rtl/fifo_seg_param_pkg.sv
// Shared constants for the segment FIFO: active-low seven-segment patterns
// (bit order a..g, MSB = a) and the nibble-to-segment decode.
package fifo_seg_pkg;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001101;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fifo_seg_param_if.sv
// Board-side bundle of the segment FIFO: active-low requests and write data in,
// read data, occupancy, status flags and display drive out.
interface fifo_seg_if #(
    parameter int DW    = 4,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    // Requests are level-sampled on divider tick edges only; there is no ready.
    // A request is taken when the matching status flag allows it, otherwise it
    // raises the sticky overflow/underflow flag.
    logic          wr_n;
    logic          rd_n;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;
    logic [6:0]    led_n;
    logic          seg_sel;

    modport master (
        output wr_n, rd_n, din,
        input  dout, count, full, empty, almost_full, almost_empty,
        input  overflow, underflow, led_n, seg_sel
    );

    modport slave (
        input  wr_n, rd_n, din,
        output dout, count, full, empty, almost_full, almost_empty,
        output overflow, underflow, led_n, seg_sel
    );

endinterface

// File: rtl/fifo_seg_param_tick_gen.sv
// Clock-enable divider: one-cycle tick every 2^DIV_W clocks, first tick
// 2^DIV_W edges after reset release; DIV_W = 0 ticks every cycle.
module tick_gen #(
    parameter int DIV_W = 24
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    generate
        if (DIV_W == 0) begin : g_every_cycle
            logic unused_clk_rst;
            assign unused_clk_rst = clk & rst;
            assign tick           = 1'b1;
        end else begin : g_divider
            logic [DIV_W-1:0] div_q;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    div_q <= '0;
                end else begin
                    div_q <= div_q + 1'b1;
                end
            end

            assign tick = &div_q;
        end
    endgenerate

endmodule

// File: rtl/fifo_seg_param.sv
// Synchronous FIFO with sticky error flags and a registered seven-segment
// readout of the last word read; requests are qualified by a divider tick.
module fifo_seg_param
    import fifo_seg_pkg::*;
#(
    parameter int DW     = 4,
    parameter int DEPTH  = 16,
    parameter int DIV_W  = 24,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  logic       clk,
    input  logic       rst,
    fifo_seg_if.slave  bus
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LVL);
    localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_LVL);

    logic          tick;
    logic          rd_acc;
    logic          wr_acc;
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q;
    logic [AW-1:0] rp_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full_q;
    logic          empty_q;
    logic          afull_q;
    logic          aempty_q;
    logic          ovf_q;
    logic          udf_q;
    logic [DW-1:0] dout_q;
    logic [6:0]    led_q;

    tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // A write into a full FIFO is legal when a read frees the slot on the same edge.
    always_comb begin
        rd_acc  = tick & ~bus.rd_n & ~empty_q;
        wr_acc  = tick & ~bus.wr_n & (~full_q | rd_acc);
        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage has no reset; a reset edge still blocks the write.
    always_ff @(posedge clk) begin
        if (rst && wr_acc) begin
            mem_q[wp_q] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q     <= '0;
            rp_q     <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            dout_q   <= '0;
            led_q    <= SEG_0;
        end else begin
            count_q  <= count_d;
            full_q   <= (count_d == FULL_CNT);
            empty_q  <= (count_d == '0);
            afull_q  <= (count_d >= AF_CNT);
            aempty_q <= (count_d <= AE_CNT);
            if (wr_acc) begin
                wp_q <= wp_q + 1'b1;
            end
            if (rd_acc) begin
                rp_q   <= rp_q + 1'b1;
                dout_q <= mem_q[rp_q];
            end
            if (tick && !bus.wr_n && !wr_acc) begin
                ovf_q <= 1'b1;
            end
            if (tick && !bus.rd_n && empty_q) begin
                udf_q <= 1'b1;
            end
            led_q <= seg_decode(dout_q[3:0]);
        end
    end

    assign bus.dout         = dout_q;
    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
    assign bus.led_n        = led_q;
    assign bus.seg_sel      = 1'b0;

endmodule

// File: tb/tb_fifo_seg_param.sv
// Bench for fifo_seg_param: a queue-based model checked every cycle against an
// undivided instance, plus directed checks on a DIV_W=4 instance.
module tb_fifo_seg_param;

    logic clk = 1'b0;
    logic rst0;
    logic rst4;

    always #5 clk = ~clk;

    fifo_seg_if #(.DW(4), .DEPTH(16)) bus0 ();
    fifo_seg_if #(.DW(4), .DEPTH(16)) bus4 ();

    fifo_seg_param #(.DW(4), .DEPTH(16), .DIV_W(0), .AF_LVL(14), .AE_LVL(2)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    fifo_seg_param #(.DW(4), .DEPTH(16), .DIV_W(4), .AF_LVL(14), .AE_LVL(2)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    logic [6:0] seg_tab [16];
    logic [3:0] mq [$];
    logic [3:0] m_dout;
    logic [6:0] m_led;
    bit         m_ovf;
    bit         m_udf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain list of words with the acceptance rules applied each edge.
    always @(posedge clk) begin
        bit rd_ok;
        bit wr_ok;
        if (!rst0) begin
            mq.delete();
            m_dout = 4'h0;
            m_led  = 7'b0000001;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            m_led = seg_tab[m_dout];
            rd_ok = !bus0.rd_n && (mq.size() != 0);
            wr_ok = !bus0.wr_n && ((mq.size() < 16) || rd_ok);
            if (!bus0.wr_n && !wr_ok) m_ovf = 1'b1;
            if (!bus0.rd_n && (mq.size() == 0)) m_udf = 1'b1;
            if (rd_ok) m_dout = mq.pop_front();
            if (wr_ok) mq.push_back(bus0.din);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_count", bus0.count, mq.size());
            chk("m_full", bus0.full, mq.size() == 16);
            chk("m_empty", bus0.empty, mq.size() == 0);
            chk("m_afull", bus0.almost_full, mq.size() >= 14);
            chk("m_aempty", bus0.almost_empty, mq.size() <= 2);
            chk("m_ovf", bus0.overflow, m_ovf);
            chk("m_udf", bus0.underflow, m_udf);
            chk("m_dout", bus0.dout, m_dout);
            chk("m_led", bus0.led_n, m_led);
            chk("m_segsel", bus0.seg_sel, 0);
        end
    end

    task automatic op0(input bit w, input bit r, input logic [3:0] d);
        bus0.wr_n = !w;
        bus0.rd_n = !r;
        bus0.din  = d;
        @(posedge clk);
        #1;
        bus0.wr_n = 1'b1;
        bus0.rd_n = 1'b1;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        rst0 = 1'b0;
        rst4 = 1'b0;
        bus0.wr_n = 1'b1; bus0.rd_n = 1'b1; bus0.din = 4'h0;
        bus4.wr_n = 1'b1; bus4.rd_n = 1'b1; bus4.din = 4'h0;

        // Reset held with random requests
        for (int i = 0; i < 3; i++) begin
            bus0.wr_n = 1'($urandom_range(0, 1));
            bus0.rd_n = 1'($urandom_range(0, 1));
            bus0.din  = 4'($urandom_range(0, 15));
            edge1();
            cmp_en = 1'b1;
        end
        chk("rst_count", bus0.count, 0);
        chk("rst_empty", bus0.empty, 1);
        chk("rst_aempty", bus0.almost_empty, 1);
        chk("rst_full", bus0.full, 0);
        chk("rst_dout", bus0.dout, 0);
        chk("rst_led", bus0.led_n, 7'b0000001);
        chk("rst_segsel", bus0.seg_sel, 0);
        bus0.wr_n = 1'b1; bus0.rd_n = 1'b1;
        rst0 = 1'b1;

        // Fill 0..F then one rejected write of 5
        for (int i = 0; i < 16; i++) begin
            op0(1, 0, 4'(i));
            if (i == 12) chk("fill_afull_13", bus0.almost_full, 0);
            if (i == 13) chk("fill_afull_14", bus0.almost_full, 1);
            if (i == 14) chk("fill_full_15", bus0.full, 0);
        end
        chk("fill_full_16", bus0.full, 1);
        chk("fill_count_16", bus0.count, 16);
        op0(1, 0, 4'h5);
        chk("ovf_set", bus0.overflow, 1);
        chk("ovf_count", bus0.count, 16);

        // Drain 0..F, then read on empty
        for (int i = 0; i < 16; i++) begin
            op0(0, 1, 4'h0);
            chk("drain_dout", bus0.dout, i);
            if (i == 10) begin
                op0(0, 0, 4'h0);
                chk("led_A", bus0.led_n, 7'b0001000);
            end
        end
        chk("drain_empty", bus0.empty, 1);
        op0(0, 1, 4'h0);
        chk("udf_set", bus0.underflow, 1);
        chk("udf_dout_hold", bus0.dout, 4'hF);

        // Simultaneous read+write at full, then at empty
        for (int i = 0; i < 16; i++) op0(1, 0, 4'((i + 8) % 16));
        op0(1, 1, 4'h7);
        chk("sim_full_count", bus0.count, 16);
        chk("sim_full_dout", bus0.dout, 8);
        for (int i = 0; i < 15; i++) begin
            op0(0, 1, 4'h0);
            chk("sim_drain", bus0.dout, (i + 9) % 16);
        end
        op0(0, 1, 4'h0);
        chk("sim_tail7", bus0.dout, 7);
        chk("sim_empty", bus0.empty, 1);
        op0(1, 1, 4'h3);
        chk("sim_empty_count", bus0.count, 1);
        chk("sim_empty_dout", bus0.dout, 7);
        op0(0, 1, 4'h0);
        chk("sim_empty_read", bus0.dout, 3);

        // Pointer wrap with clean flags
        rst0 = 1'b0;
        op0(0, 0, 4'h0);
        op0(0, 0, 4'h0);
        rst0 = 1'b1;
        chk("wrap_rst_ovf", bus0.overflow, 0);
        for (int i = 0; i < 10; i++) op0(1, 0, 4'((i * 3 + 1) % 16));
        for (int i = 0; i < 10; i++) begin
            op0(0, 1, 4'h0);
            chk("wrap_rd1", bus0.dout, (i * 3 + 1) % 16);
        end
        for (int i = 0; i < 12; i++) op0(1, 0, 4'((i * 5 + 2) % 16));
        chk("wrap_peak", bus0.count, 12);
        for (int i = 0; i < 12; i++) begin
            op0(0, 1, 4'h0);
            chk("wrap_rd2", bus0.dout, (i * 5 + 2) % 16);
        end
        chk("wrap_ovf", bus0.overflow, 0);
        chk("wrap_udf", bus0.underflow, 0);
        chk("wrap_empty", bus0.empty, 1);

        // Divided instance: first tick 16 edges after release
        rst4 = 1'b1;
        bus4.wr_n = 1'b0;
        bus4.din  = 4'h9;
        for (int e = 1; e <= 16; e++) begin
            edge1();
            chk("div_first_tick", bus4.count, (e == 16) ? 1 : 0);
        end
        bus4.wr_n = 1'b1;
        bus4.rd_n = 1'b0;
        for (int e = 0; e < 5; e++) edge1();
        chk("div_ignored_rd", bus4.count, 1);
        chk("div_ignored_udf", bus4.underflow, 0);
        bus4.rd_n = 1'b1;

        // Reset with a pending write, then release and time the next tick
        rst4 = 1'b0;
        bus4.wr_n = 1'b0;
        edge1();
        chk("div_rst_count", bus4.count, 0);
        chk("div_rst_empty", bus4.empty, 1);
        chk("div_rst_led", bus4.led_n, 7'b0000001);
        rst4 = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            edge1();
            chk("div_retick", bus4.count, (e == 16) ? 1 : 0);
        end
        bus4.wr_n = 1'b1;
        for (int e = 0; e < 15; e++) edge1();
        // Next edge is a tick edge; reset must win and drop the write
        rst4 = 1'b0;
        bus4.wr_n = 1'b0;
        edge1();
        chk("div_rst_on_tick", bus4.count, 0);
        chk("div_rst_ovf", bus4.overflow, 0);
        chk("div_segsel", bus4.seg_sel, 0);
        bus4.wr_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_seg_param.md
# fifo_seg_param

Parametrised synchronous FIFO with an on-board request-rate divider and a seven-segment readout of the last word read. It sits between the board's active-low push-button/switch inputs and the single-digit display. It generalises the 4-bit × 16 demo FIFO with configurable width, depth, almost-full/almost-empty levels, an occupancy count and sticky overflow/underflow flags. The whole block runs on one clock domain, using a clock-enable tick in place of a derived clock.

## Interface
- DW, 4: data width in bits, ≥4.
- DEPTH, 16: number of entries; power of two, ≥4.
- AW, $clog2(DEPTH): pointer width (derived, not overridden).
- DIV_W, 24: tick divider width; 0 means tick every cycle.
- AF_LVL, DEPTH-2: almost_full asserts when count ≥ AF_LVL.
- AE_LVL, 2: almost_empty asserts when count ≤ AE_LVL.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- wr_n  in  1  write request, active-low.
- rd_n  in  1  read request, active-low.
- din  in  DW  write data.
- dout  out  DW  last word read (registered).
- count  out  AW+1  occupancy, 0..DEPTH.
- full, empty, almost_full, almost_empty  out  1 each  status flags (registered).
- overflow, underflow  out  1 each  sticky error flags.
- led_n  out  7  segments a..g of the display, active-low; decode of dout[3:0].
- seg_sel  out  1  digit enable, active-low; held at 0.

## Operation
- Tick generator:
  - DIV_W-bit counter increments every clk.
  - tick=1 for one cycle when the counter is all ones, then the counter wraps to 0.
  - DIV_W=0: tick is constant 1.
- wr_n/rd_n/din are sampled only on clk edges where tick=1; they are ignored otherwise.
- Accepted read (rd_acc): rd_n=0 and !empty.
- Accepted write (wr_acc): wr_n=0 and (!full or rd_acc). A write on full is therefore allowed when paired with a read.
- wr_acc: mem[wp]<=din; wp<=wp+1, wrapping modulo DEPTH.
- rd_acc: dout<=mem[rp]; rp<=rp+1, wrapping.
- count update:
  - +1 on wr_acc only.
  - −1 on rd_acc only.
  - Unchanged on both or neither.
- Flags are computed from the next value of count and registered in the same edge:
  - full = (count==DEPTH)
  - empty = (count==0)
  - almost_full, almost_empty per the AF_LVL / AE_LVL rules above.
- Empty with both requests: write only. No bypass; dout is unchanged.
- overflow set on a tick with wr_n=0 and !wr_acc; underflow set on a tick with rd_n=0 and empty. Both clear only on reset.
- Memory contents are never altered by a rejected write.
- led_n is a registered decode of dout[3:0] (abcdefg, active-low):
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001101
  - 8:0000000, 9:0000100, A:0001000, B:1100000
  - C:0110001, D:1000010, E:0110000, F:0111000
- Reset values: rp=wp=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=underflow=0, dout=0, led_n=0000001, seg_sel=0, divider=0. Memory is not reset.

## Timing
- Status and count reflect an operation on the same clk edge that samples it (tick edge).
- dout is valid immediately after the read edge.
- led_n follows dout one clk later.
- After reset release, the first tick occurs 2^DIV_W clk edges later.
- Reset asserted mid-operation, including on a tick edge, takes priority on that edge. Any request on that edge is discarded.
- No combinational path from inputs to outputs.

## Structure
- Package fifo_seg_pkg holds:
  - SEG_0..SEG_F 7-bit constants.
  - function seg_decode(logic [3:0]) returning logic [6:0].
- Sub-module tick_gen (parameter DIV_W; ports clk, rst, tick) holds the divider. The FIFO core and decode stay in fifo_seg_param.

## Test plan
Unless stated, DW=4, DEPTH=16, DIV_W=0, AF_LVL=14, AE_LVL=2.
- Reset: hold rst=0 for 3 cycles with random requests → count=0, empty=1, almost_empty=1, full=0, dout=0, led_n=0000001, seg_sel=0.
- Fill: write 0..F, then one more write of 5 → almost_full rises at count=14, full at 16, overflow=1, count stays 16, memory unchanged.
- Drain: 16 reads → dout sequence 0..F. When dout=A, led_n=0001000 one cycle later. empty=1 after the 16th read. A 17th read → underflow=1, dout holds F.
- Simultaneous: at full, write 7 with a read → count=16, dout=oldest, 7 stored at the tail. At empty, both requests → count=1, dout unchanged.
- Wrap: write 10, read 10, write 12, read 12 → count peaks at 12, order preserved across pointer wrap, no flags set.
- Divider/reset: DIV_W=4 → tick every 16 clk, requests between ticks ignored. Pull rst low 5 cycles after a write → all cleared next edge, first tick 16 edges after release.
